adder_sequencer: RTL and testbench



---
 rtl/adder_sequencer_pkg.sv | 16 +
 rtl/adder_sequencer_byte_add_stage.sv | 27 ++
 rtl/adder_sequencer.sv | 158 +++++++++++++++
 tb/tb_adder_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the adder_sequencer slice: FSM state encoding,
// operation codes and the byte width of the shared adder stage.
package emu_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_sequencer_byte_add_stage.sv
// byte_add_stage: purely combinational 8-bit adder with carry-in.
// Ports:
//   a, b  in  8  operand bytes
//   cin   in  1  carry into bit 0
//   s     out 8  sum byte
//   cout  out 1  carry out of bit 7
//   c7    out 1  carry into bit 7 (used for two's-complement overflow)
module byte_add_stage
  import emu_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout,
  output logic              c7
);

  logic [BYTE_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign s      = w_full[BYTE_W-1:0];
  assign cout   = w_full[BYTE_W];
  // Sum bit 7 = a7 ^ b7 ^ c7, so the carry into bit 7 falls out directly.
  assign c7     = w_full[BYTE_W-1] ^ a[BYTE_W-1] ^ b[BYTE_W-1];

endmodule

// File: rtl/adder_sequencer.sv
// adder_sequencer: multi-byte add/subtract sequencer. Two requesters share one
// 8-bit adder stage under round-robin arbitration; operands are processed one
// byte per cycle, LSB first, with the carry chained through a register.
// Optional feature macro: ADDSEQ_SUB_EN (when undefined, reqN_op is ignored and
// every operation is an add with carry-in 0).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake (ready is combinational, IDLE only)
//   reqN_a, reqN_b, reqN_op    W-bit operands, 0 = add, 1 = subtract (A-B)
//   res_valid/res_ready        result handshake
//   res_sum, res_cout, res_ovf W-bit result, carry out, signed overflow
//   res_id                     requester that owns the result
module adder_sequencer
  import emu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [8*NBYTES-1:0]    req0_a,
  input  logic [8*NBYTES-1:0]    req0_b,
  input  logic                   req0_op,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [8*NBYTES-1:0]    req1_a,
  input  logic [8*NBYTES-1:0]    req1_b,
  input  logic                   req1_op,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*NBYTES-1:0]    res_sum,
  output logic                   res_cout,
  output logic                   res_ovf,
  output logic                   res_id
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t          r_state;
  logic            r_ptr;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_id;
  logic            r_valid;

  logic              w_gnt_id;
  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_raw;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_s;
  logic              w_cout;
  logic              w_c7;

  // Grant pointer names the requester preferred on a tie; a lone request wins.
  always_comb begin
    w_gnt_id = req1_valid;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_ptr;
    end
  end

  assign req0_ready = rst_n && (r_state == IDLE) && req0_valid && !w_gnt_id;
  assign req1_ready = rst_n && (r_state == IDLE) && req1_valid &&  w_gnt_id;

  assign w_a_byte = r_a[int'(r_idx)*BYTE_W +: BYTE_W];
  assign w_b_raw  = r_b[int'(r_idx)*BYTE_W +: BYTE_W];

`ifdef ADDSEQ_SUB_EN
  logic r_op;
  logic w_sel_op;
  assign w_sel_op = w_gnt_id ? req1_op : req0_op;
  assign w_b_byte = (r_op == OP_SUB) ? ~w_b_raw : w_b_raw;
`else
  logic w_unused_op;
  assign w_unused_op = req0_op ^ req1_op;
  assign w_b_byte    = w_b_raw;
`endif

  byte_add_stage u_stage (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c7   (w_c7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_id    <= 1'b0;
      r_valid <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      r_op    <= OP_ADD;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            r_a     <= w_gnt_id ? req1_a : req0_a;
            r_b     <= w_gnt_id ? req1_b : req0_b;
            r_idx   <= '0;
            r_id    <= w_gnt_id;
            r_ptr   <= ~w_gnt_id;
`ifdef ADDSEQ_SUB_EN
            r_op    <= w_sel_op;
            r_carry <= w_sel_op;
`else
            r_carry <= 1'b0;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*BYTE_W +: BYTE_W] <= w_s;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c7 ^ w_cout;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_valid;
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;
  assign res_id    = r_id;

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_op = 1'b0, req1_op = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf, res_id;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         id;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  adder_sequencer #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ovf    (res_ovf),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] sum, input logic cout,
                              input logic ovf, input logic id);
    exp_t e;
    e.sum = sum; e.cout = cout; e.ovf = ovf; e.id = id;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every consumed result is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_result", $sformatf("got sum 0x%0h, expected no result", res_sum));
      end else begin
        m_e = sb_q.pop_front();
        check("res_sum",  32'(res_sum),  32'(m_e.sum));
        check("res_cout", 32'(res_cout), 32'(m_e.cout));
        check("res_ovf",  32'(res_ovf),  32'(m_e.ovf));
        check("res_id",   32'(res_id),   32'(m_e.id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    if (r == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the handshake edge.
  task automatic wait_grant(input int r);
    int   n;
    logic g;
    n = 0;
    #1;
    g = (r == 0) ? req0_ready : req1_ready;
    while (!g && n < 50) begin
      @(posedge clk);
      #2;
      g = (r == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!g) fail_now("grant_timeout", $sformatf("requester %0d got no ready, expected one within 50 cycles", r));
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || res_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_now("drain_timeout", $sformatf("%0d results still pending, expected 0", sb_q.size()));
    tick();
  endtask

  task automatic do_single(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic op, input exp_t e);
    sb_q.push_back(e);
    set_req(r, a, b, op);
    wait_grant(r);
    drain();
  endtask

  task automatic run_pair(input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input exp_t e0, input exp_t e1, input string tag);
    int   n;
    int   first;
    logic g0, g1;
    n = 0;
    first = -1;
    sb_q.push_back(e0);
    sb_q.push_back(e1);
    set_req(0, a0, b0, 1'b0);
    set_req(1, a1, b1, 1'b0);
    while ((req0_valid || req1_valid) && n < 100) begin
      #1;
      g0 = req0_ready;
      g1 = req1_ready;
      if (first < 0 && (g0 || g1)) first = g1 ? 1 : 0;
      @(posedge clk);
      #1;
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
      n++;
    end
    if (n >= 100) fail_now({tag, "_timeout"}, "requests still pending, expected both granted");
    check({tag, "_first_grant"}, 32'(first), 32'd0);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state, with a request already pending during reset.
    req0_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_sum",    32'(res_sum),    32'd0);
    check("rst_res_cout",   32'(res_cout),   32'd0);
    check("rst_res_ovf",    32'(res_ovf),    32'd0);
    check("rst_res_id",     32'(res_id),     32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Arbitration: both valid, req0 first; req1 was last, so req0 first again.
    run_pair(16'h1000, 16'h0234, 16'h00F0, 16'h0F10,
             mk(16'h1234, 1'b0, 1'b0, 1'b0), mk(16'h1000, 1'b0, 1'b0, 1'b1), "arb1");
    run_pair(16'h8000, 16'h8000, 16'hFF00, 16'h0100,
             mk(16'h0000, 1'b1, 1'b1, 1'b0), mk(16'h0000, 1'b1, 1'b0, 1'b1), "arb2");

    // Byte carry propagation plus latency from the handshake edge.
    sb_q.push_back(mk(16'h0100, 1'b0, 1'b0, 1'b0));
    set_req(0, 16'h00FF, 16'h0001, 1'b0);
    wait_grant(0);
    check("lat_edge1", 32'(res_valid), 32'd0);
    tick();
    check("lat_edge2", 32'(res_valid), 32'd0);
    tick();
    check("lat_edge3", 32'(res_valid), 32'd1);
    drain();

    do_single(1, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    do_single(1, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b1));

`ifdef ADDSEQ_SUB_EN
    do_single(0, 16'h0100, 16'h0001, 1'b1, mk(16'h00FF, 1'b1, 1'b0, 1'b0));
    do_single(1, 16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b1));
    do_single(0, 16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
`else
    do_single(0, 16'h0003, 16'h0001, 1'b1, mk(16'h0004, 1'b0, 1'b0, 1'b0));
`endif

    // Back-pressure: result frozen, no new grant while DONE.
    res_ready = 1'b0;
    sb_q.push_back(mk(16'h2345, 1'b0, 1'b0, 1'b0));
    set_req(0, 16'h1234, 16'h1111, 1'b0);
    wait_grant(0);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_reach_done", 32'(res_valid), 32'd1);
    sb_q.push_back(mk(16'h0002, 1'b0, 1'b0, 1'b1));
    set_req(1, 16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_res_sum",    32'(res_sum),    32'h2345);
      check("bp_res_valid",  32'(res_valid),  32'd1);
      check("bp_res_id",     32'(res_id),     32'd0);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    check("bp_idle_valid", 32'(res_valid),  32'd0);
    check("bp_idle_grant", 32'(req1_ready), 32'd1);
    wait_grant(1);
    drain();

    // Reset in the second RUN cycle aborts the operation immediately.
    set_req(0, 16'h1111, 16'h2222, 1'b0);
    wait_grant(0);
    tick();
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_res_valid",  32'(res_valid),  32'd0);
    check("abort_res_sum",    32'(res_sum),    32'd0);
    check("abort_req1_ready", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_pair(16'h4321, 16'h1234, 16'h0F0F, 16'hF0F0,
             mk(16'h5555, 1'b0, 1'b0, 1'b0), mk(16'hFFFF, 1'b0, 1'b0, 1'b1), "post_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
